// File: rtl/btle_tx_pkg.sv
// rtl/btle_tx_pkg.sv - shared state encoding and constants for the BLE frame transmitter
package btle_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PREAMBLE    = 3'd1,
        ST_ACCESS_ADDR = 3'd2,
        ST_PDU         = 3'd3,
        ST_CRC         = 3'd4
    } btle_state_t;

    localparam logic [7:0]  PREAMBLE_EVEN = 8'hAA;
    localparam logic [7:0]  PREAMBLE_ODD  = 8'h55;
    // x^24+x^10+x^9+x^6+x^4+x^3+x+1, x^24 implied by the shift-out
    localparam logic [23:0] CRC_POLY      = 24'h00065B;
    // x^7+x^4+1, x^7 implied by the shift-out
    localparam logic [6:0]  WHITEN_TAPS   = 7'h11;
    localparam logic [6:0]  MAX_PDU_LEN   = 7'd62;

    function automatic logic [6:0] clamp_pdu_len(input logic [6:0] raw_len);
        return (raw_len > MAX_PDU_LEN) ? MAX_PDU_LEN : raw_len;
    endfunction

endpackage

// File: rtl/crc24_core.sv
// rtl/crc24_core.sv - bit-serial CRC register, one data bit per advance
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   init, init_value    load the CRC register
//   advance, data_in    shift one message bit in
//   crc                 current CRC register
module crc24_core #(
    parameter int               WIDTH = 24,
    parameter logic [WIDTH-1:0] POLY  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init,
    input  logic [WIDTH-1:0] init_value,
    input  logic             advance,
    input  logic             data_in,
    output logic [WIDTH-1:0] crc
);

    logic feedback;

    assign feedback = crc[WIDTH-1] ^ data_in;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc <= '0;
        end else if (init) begin
            crc <= init_value;
        end else if (advance) begin
            crc <= {crc[WIDTH-2:0], 1'b0} ^ ({WIDTH{feedback}} & POLY);
        end
    end

endmodule

// File: rtl/scramble_core.sv
// rtl/scramble_core.sv - Galois LFSR whitening sequence generator
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   init, seed   load the LFSR with seed
//   advance      step the LFSR by one bit
//   bit_out      current whitening bit (LFSR MSB)
module scramble_core #(
    parameter int               WIDTH = 7,
    parameter logic [WIDTH-1:0] TAPS  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init,
    input  logic [WIDTH-1:0] seed,
    input  logic             advance,
    output logic             bit_out
);

    logic [WIDTH-1:0] lfsr;

    assign bit_out = lfsr[WIDTH-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr <= '0;
        end else if (init) begin
            lfsr <= seed;
        end else if (advance) begin
            lfsr <= {lfsr[WIDTH-2:0], 1'b0} ^ ({WIDTH{lfsr[WIDTH-1]}} & TAPS);
        end
    end

endmodule

// File: rtl/btle_tx.sv
// rtl/btle_tx.sv - BLE link-layer frame serializer: preamble, access address, whitened PDU and CRC
// Ports:
//   clk, rst_n                 clock and synchronous active-low reset
//   unique_bit_sequence        access address, sampled on start
//   channel_number             whitening seed, sampled on start
//   crc_state_init_bit         CRC init value, sampled on start
//   start                      one-cycle frame request (ignored while busy)
//   sample_strobe              output-sample enable
//   pdu_octet_mem_addr/_data   PDU RAM read port, data one cycle after address
//   busy                       frame in progress
//   tx_symbol, tx_sample_valid NRZ output sample
//   payload_length             latched clamped PDU length
//   tx_end                     one-cycle end-of-frame pulse
module btle_tx
    import btle_tx_pkg::*;
#(
    parameter int SAMPLE_PER_SYMBOL        = 8,
    parameter int LEN_UNIQUE_BIT_SEQUENCE  = 32,
    parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
    parameter int CRC_STATE_BIT_WIDTH      = 24
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [LEN_UNIQUE_BIT_SEQUENCE-1:0]  unique_bit_sequence,
    input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number,
    input  logic [CRC_STATE_BIT_WIDTH-1:0]      crc_state_init_bit,
    input  logic                                start,
    input  logic                                sample_strobe,
    output logic [5:0]                          pdu_octet_mem_addr,
    input  logic [7:0]                          pdu_octet_mem_data,
    output logic                                busy,
    output logic                                tx_symbol,
    output logic                                tx_sample_valid,
    output logic [6:0]                          payload_length,
    output logic                                tx_end
);

    localparam int WHITEN_W = CHANNEL_NUMBER_BIT_WIDTH + 1;

    btle_state_t                        state, state_next;
    logic [4:0]                         bit_cnt;
    logic [5:0]                         octet_cnt;
    logic [3:0]                         phase;
    logic [7:0]                         preamble;
    logic [LEN_UNIQUE_BIT_SEQUENCE-1:0] aa;
    logic [7:0]                         cur_octet;
    logic [CRC_STATE_BIT_WIDTH-1:0]     crc_value;
    logic                               whiten_bit;
    logic                               strobe_act, bit_done, field_last, octet_end, cur_bit;
    logic [4:0]                         crc_idx;
    logic [6:0]                         last_octet, next_idx, new_len, new_last;

    assign busy       = (state != ST_IDLE);
    assign strobe_act = busy && sample_strobe;
    assign bit_done   = strobe_act && (phase == 4'(SAMPLE_PER_SYMBOL - 1));
    assign octet_end  = (bit_cnt[2:0] == 3'd7);
    assign last_octet = payload_length + 7'd1;
    assign crc_idx    = 5'(CRC_STATE_BIT_WIDTH - 1) - bit_cnt;

    scramble_core #(.WIDTH(WHITEN_W), .TAPS(WHITEN_TAPS)) u_whiten (
        .clk     (clk),
        .rst_n   (rst_n),
        .init    (!busy && start),
        .seed    ({1'b1, channel_number}),
        .advance (bit_done && (state == ST_PDU || state == ST_CRC)),
        .bit_out (whiten_bit)
    );

    // CRC runs over the raw (un-whitened) PDU bit
    crc24_core #(.WIDTH(CRC_STATE_BIT_WIDTH), .POLY(CRC_POLY)) u_crc (
        .clk        (clk),
        .rst_n      (rst_n),
        .init       (!busy && start),
        .init_value (crc_state_init_bit),
        .advance    (bit_done && state == ST_PDU),
        .data_in    (cur_octet[bit_cnt[2:0]]),
        .crc        (crc_value)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        field_last = 1'b0;
        cur_bit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
                field_last = (bit_cnt == 5'd7);
                cur_bit    = preamble[bit_cnt[2:0]];
                if (bit_done && field_last) state_next = ST_ACCESS_ADDR;
            end
            ST_ACCESS_ADDR: begin
                field_last = (bit_cnt == 5'(LEN_UNIQUE_BIT_SEQUENCE - 1));
                cur_bit    = aa[bit_cnt];
                if (bit_done && field_last) state_next = ST_PDU;
            end
            ST_PDU: begin
                field_last = octet_end && ({1'b0, octet_cnt} == last_octet);
                cur_bit    = cur_octet[bit_cnt[2:0]] ^ whiten_bit;
                if (bit_done && field_last) state_next = ST_CRC;
            end
            ST_CRC: begin
                field_last = (bit_cnt == 5'(CRC_STATE_BIT_WIDTH - 1));
                cur_bit    = crc_value[crc_idx] ^ whiten_bit;
                if (bit_done && field_last) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Octet 1 carries the length, so when it is being loaded the last-octet
    // index must come from the RAM data rather than the stale register.
    always_comb begin
        new_len  = clamp_pdu_len(pdu_octet_mem_data[6:0]);
        next_idx = {1'b0, octet_cnt} + 7'd1;
        new_last = (octet_cnt == 6'd0) ? new_len + 7'd1 : last_octet;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt            <= '0;
            octet_cnt          <= '0;
            phase              <= '0;
            preamble           <= '0;
            aa                 <= '0;
            cur_octet          <= '0;
            payload_length     <= '0;
            pdu_octet_mem_addr <= '0;
            tx_symbol          <= 1'b0;
            tx_sample_valid    <= 1'b0;
            tx_end             <= 1'b0;
        end else begin
            tx_sample_valid <= strobe_act;
            tx_end          <= 1'b0;
            if (strobe_act) begin
                tx_symbol <= cur_bit;
            end else if (!busy) begin
                tx_symbol <= 1'b0;
            end

            if (!busy) begin
                bit_cnt            <= '0;
                octet_cnt          <= '0;
                phase              <= '0;
                pdu_octet_mem_addr <= '0;
                if (start) begin
                    preamble <= unique_bit_sequence[0] ? PREAMBLE_ODD : PREAMBLE_EVEN;
                    aa       <= unique_bit_sequence;
                end
            end else if (strobe_act) begin
                phase <= bit_done ? 4'd0 : phase + 4'd1;
                if (bit_done) begin
                    bit_cnt <= field_last ? 5'd0 : bit_cnt + 5'd1;
                    case (state)
                        ST_ACCESS_ADDR: begin
                            if (field_last) begin
                                cur_octet          <= pdu_octet_mem_data;
                                pdu_octet_mem_addr <= 6'd1;
                            end
                        end
                        ST_PDU: begin
                            if (octet_end) begin
                                bit_cnt <= 5'd0;
                                if (field_last) begin
                                    pdu_octet_mem_addr <= 6'd0;
                                end else begin
                                    octet_cnt <= next_idx[5:0];
                                    cur_octet <= pdu_octet_mem_data;
                                    if (octet_cnt == 6'd0) payload_length <= new_len;
                                    // prefetch the octet after the one now starting
                                    pdu_octet_mem_addr <= (next_idx == new_last) ? 6'd0
                                                        : 6'(next_idx + 7'd1);
                                end
                            end
                        end
                        ST_CRC: begin
                            if (field_last) tx_end <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/btle_tx.md
BTLE_TX -- requirements
Module: btle_tx

Interface
REQ-001 Parameter SAMPLE_PER_SYMBOL, default 8, output samples per symbol; legal range 2..16.
REQ-002 Parameter LEN_UNIQUE_BIT_SEQUENCE, default 32, access address width.
REQ-003 Parameter CHANNEL_NUMBER_BIT_WIDTH, default 6, channel number width.
REQ-004 Parameter CRC_STATE_BIT_WIDTH, default 24, CRC register width.
REQ-005 Port clk, input, 1, single clock; all logic in this domain.
REQ-006 Port rst_n, input, 1; reset is synchronous and active-low.
REQ-007 Port unique_bit_sequence, input, LEN_UNIQUE_BIT_SEQUENCE, access address; sampled at start.
REQ-008 Port channel_number, input, CHANNEL_NUMBER_BIT_WIDTH, whitening seed; sampled at start.
REQ-009 Port crc_state_init_bit, input, CRC_STATE_BIT_WIDTH, CRC init; sampled at start.
REQ-010 Port start, input, 1, one-cycle frame request.
REQ-011 Port sample_strobe, input, 1, output-sample enable; arbitrary gaps are allowed.
REQ-012 Port pdu_octet_mem_addr, output, 6, PDU RAM read address.
REQ-013 Port pdu_octet_mem_data, input, 8, RAM read data, valid 1 cycle after the address.
REQ-014 Port busy, output, 1, frame in progress.
REQ-015 Port tx_symbol, output, 1, current NRZ symbol (1 = +deviation).
REQ-016 Port tx_sample_valid, output, 1, one pulse per output sample.
REQ-017 Port payload_length, output, 7, latched clamped PDU length.
REQ-018 Port tx_end, output, 1, one-cycle end-of-frame pulse.

Function
REQ-019 Frame order: preamble (8) -> access address (32) -> PDU (8*(L+2)) -> CRC (24); every field is sent LSB first except CRC.
REQ-020 Preamble: 0xAA when unique_bit_sequence[0]=0, else 0x55.
REQ-021 PDU octet 0 is the header, octet 1 is the length; L = octet1[6:0] clamped to 62, latched when octet 1 is loaded, and driven on payload_length.
REQ-022 CRC: polynomial x^24+x^10+x^9+x^6+x^4+x^3+x+1, initialised to crc_state_init_bit, computed over un-whitened PDU bits, transmitted register MSB first.
REQ-023 Whitening: LFSR x^7+x^4+1 seeded {1, channel_number}, applied to PDU and CRC bits only.
REQ-024 FSM states and transitions: IDLE -> PREAMBLE -> ACCESS_ADDR -> PDU -> CRC -> IDLE; one bit counter (0..31) and one octet counter (0..63).
REQ-025 start is accepted only in IDLE; busy asserts the next cycle; start while busy is ignored.
REQ-026 Each sample_strobe while busy produces tx_sample_valid=1 on the next cycle, with tx_symbol equal to the current bit.
REQ-027 The block advances one bit after SAMPLE_PER_SYMBOL strobes; the sample-phase counter wraps from SAMPLE_PER_SYMBOL-1 to 0.
REQ-028 pdu_octet_mem_addr is set to octet n+1 when octet n starts transmission; the next octet register is loaded at the octet boundary.
REQ-029 Address 0 is presented in IDLE, so octet 0 is ready at PDU entry.
REQ-030 tx_end pulses on the cycle after the last sample of CRC bit 23; busy deasserts on the same cycle.
REQ-031 sample_strobe in IDLE is ignored: tx_sample_valid=0, tx_symbol=0.
REQ-032 Total symbols per frame = 80 + 8*L.

Reset
REQ-033 While rst_n=0 at a clk edge: FSM=IDLE, all counters 0, busy=0, tx_symbol=0, tx_sample_valid=0, tx_end=0, payload_length=0, pdu_octet_mem_addr=0.
REQ-034 Reset mid-frame aborts the frame with no tx_end pulse; the next start runs a complete frame.

Structure
REQ-035 A shared package holds the FSM state encoding, the constants PREAMBLE_EVEN=0xAA, PREAMBLE_ODD=0x55, CRC polynomial taps, whitening taps and MAX_PDU_LEN=62.
REQ-036 The block instantiates the existing scramble_core and crc24_core, ported to the active-low reset; no new sub-module is created.

Verification
REQ-037 Reset: hold rst_n=0 for 3 cycles -> all outputs 0, busy=0.
REQ-038 AA=0x8E89BED6, strobe every cycle -> the first 16 symbols are 0,1,0,1,0,1,0,1,0,1,1,0,1,0,1,1, each held for 8 samples.
REQ-039 L=0, channel 37, CRC init 0x555555 -> exactly 640 tx_sample_valid pulses, tx_end once, bits match the golden BLE model.
REQ-040 Header length byte 0x46 (70) -> payload_length=62, addresses 0..63 are read, 576 symbols are produced.
REQ-041 start while busy -> no effect; rst_n=0 during PDU -> busy=0 next cycle, no tx_end; a re-start produces a correct frame.
REQ-042 Random gaps of 0..5 cycles between strobes -> the symbol sequence is identical to the back-to-back case.
